// File: rtl/stream_delay.sv
// Valid/ready stage that holds back each handshake by a fixed or LFSR-chosen number
// of cycles; the payload itself passes straight through.
module stream_delay #(
   parameter bit          StallRandom = 1'b0,
   parameter int unsigned FixedDelay  = 1,
   parameter type         payload_t   = logic
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  payload_t payload_i,
   input  logic     valid_i,
   output logic     ready_o,
   output payload_t payload_o,
   output logic     valid_o,
   input  logic     ready_i
);

   assign payload_o = payload_i;

   if (!StallRandom && FixedDelay == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
      assign valid_o        = valid_i;
      assign ready_o        = ready_i;
   end else begin : g_delay
      localparam int unsigned MaxDelay = (FixedDelay > 16) ? FixedDelay : 16;
      localparam int unsigned CntW     = $clog2(MaxDelay + 1);

      typedef enum logic {IDLE, VALID} state_e;

      state_e          state_q;
      logic [CntW-1:0] cnt_q;
      logic [CntW-1:0] d_q;
      logic            armed_q;
      logic [CntW-1:0] d_fresh;
      logic [CntW-1:0] d_cur;
      logic [CntW-1:0] d_last;
      logic            pass_now;

      if (StallRandom) begin : g_rand
         logic [15:0] lfsr_q;

         // Fibonacci LFSR, taps 16,14,13,11; free-running so each transfer sees a new draw
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               lfsr_q <= 16'hACE1;
            end else begin
               lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            end
         end

         assign d_fresh = CntW'(lfsr_q[3:0]);
      end else begin : g_fixed
         assign d_fresh = CntW'(FixedDelay);
      end

      // Delay is latched on the first presenting cycle so it stays put for the whole transfer
      assign d_cur    = armed_q ? d_q : d_fresh;
      assign d_last   = d_cur - CntW'(1);
      assign pass_now = (state_q == IDLE) && (d_cur == '0);

      always_comb begin
         valid_o = 1'b0;
         ready_o = 1'b0;
         if (!rst_i) begin
            if (state_q == VALID) begin
               valid_o = valid_i;
               ready_o = ready_i & valid_i;
            end else if (pass_now) begin
               valid_o = valid_i;
               ready_o = ready_i;
            end
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
         end else if (state_q == IDLE) begin
            if (!valid_i) begin
               cnt_q   <= '0;
               armed_q <= 1'b0;
            end else if (d_cur == '0) begin
               armed_q <= !ready_i;
            end else if (cnt_q == d_last) begin
               cnt_q   <= '0;
               state_q <= VALID;
               armed_q <= 1'b1;
            end else begin
               cnt_q   <= cnt_q + CntW'(1);
               armed_q <= 1'b1;
            end
         end else begin
            if (!valid_i || ready_i) begin
               state_q <= IDLE;
               armed_q <= 1'b0;
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (state_q == IDLE && valid_i && !armed_q) begin
            d_q <= d_fresh;
         end
      end
   end

endmodule

// File: tb/tb_stream_delay.sv
// Directed bench for stream_delay: pass-through, fixed delays 1..4 and LFSR random mode
// instances share one upstream stimulus; each task checks only its own instance.
module tb_stream_delay;

   typedef logic [7:0] byte_t;

   logic            clk = 1'b0;
   logic            rst;
   byte_t           pin;
   logic            vin;
   logic            rin;
   logic [5:0]      vo;
   logic [5:0]      ro;
   logic [5:0][7:0] po;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   stream_delay #(.StallRandom(1'b0), .FixedDelay(0), .payload_t(byte_t)) u_d0 (
      .clk_i(clk), .rst_i(rst), .payload_i(pin), .valid_i(vin), .ready_o(ro[0]),
      .payload_o(po[0]), .valid_o(vo[0]), .ready_i(rin));
   stream_delay #(.StallRandom(1'b0), .FixedDelay(1), .payload_t(byte_t)) u_d1 (
      .clk_i(clk), .rst_i(rst), .payload_i(pin), .valid_i(vin), .ready_o(ro[1]),
      .payload_o(po[1]), .valid_o(vo[1]), .ready_i(rin));
   stream_delay #(.StallRandom(1'b0), .FixedDelay(2), .payload_t(byte_t)) u_d2 (
      .clk_i(clk), .rst_i(rst), .payload_i(pin), .valid_i(vin), .ready_o(ro[2]),
      .payload_o(po[2]), .valid_o(vo[2]), .ready_i(rin));
   stream_delay #(.StallRandom(1'b0), .FixedDelay(3), .payload_t(byte_t)) u_d3 (
      .clk_i(clk), .rst_i(rst), .payload_i(pin), .valid_i(vin), .ready_o(ro[3]),
      .payload_o(po[3]), .valid_o(vo[3]), .ready_i(rin));
   stream_delay #(.StallRandom(1'b0), .FixedDelay(4), .payload_t(byte_t)) u_d4 (
      .clk_i(clk), .rst_i(rst), .payload_i(pin), .valid_i(vin), .ready_o(ro[4]),
      .payload_o(po[4]), .valid_o(vo[4]), .ready_i(rin));
   stream_delay #(.StallRandom(1'b1), .FixedDelay(1), .payload_t(byte_t)) u_rnd (
      .clk_i(clk), .rst_i(rst), .payload_i(pin), .valid_i(vin), .ready_o(ro[5]),
      .payload_o(po[5]), .valid_o(vo[5]), .ready_i(rin));

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   task automatic go_idle();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vin = 1'b0;
         rin = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      vin = 1'b1;
      rin = 1'b1;
      pin = 8'h3C;
      #1;
      for (int i = 1; i < 6; i++) begin
         vectors++;
         if (vo[i] !== 1'b0 || ro[i] !== 1'b0 || po[i] !== 8'h3C) begin
            errors++;
            $display("FAIL reset_outputs inst%0d: valid=%b ready=%b payload=%h, want 0 0 3c",
                     i, vo[i], ro[i], po[i]);
         end
      end
      vectors++;
      if (vo[0] !== 1'b1 || ro[0] !== 1'b1) begin
         errors++;
         $display("FAIL reset_passthru: valid=%b ready=%b, want 1 1", vo[0], ro[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      vin = 1'b0;
      #1;
      vectors++;
      if (vo !== 6'b0) begin
         errors++;
         $display("FAIL after_reset_idle: valid=%b, want 000000", vo);
      end
   endtask

   task automatic test_passthrough();
      @(negedge clk);
      vin = 1'b1;
      rin = 1'b1;
      pin = 8'h5A;
      #1;
      vectors++;
      if (vo[0] !== 1'b1 || ro[0] !== 1'b1 || po[0] !== 8'h5A) begin
         errors++;
         $display("FAIL passthru_hs: valid=%b ready=%b payload=%h, want 1 1 5a", vo[0], ro[0], po[0]);
      end
      rin = 1'b0;
      #1;
      vectors++;
      if (vo[0] !== 1'b1 || ro[0] !== 1'b0) begin
         errors++;
         $display("FAIL passthru_stall: valid=%b ready=%b, want 1 0", vo[0], ro[0]);
      end
      vin = 1'b0;
      rin = 1'b1;
      #1;
      vectors++;
      if (vo[0] !== 1'b0 || ro[0] !== 1'b1) begin
         errors++;
         $display("FAIL passthru_novalid: valid=%b ready=%b, want 0 1", vo[0], ro[0]);
      end
   endtask

   task automatic test_fixed_delay3();
      int  hs = 0;
      logic exp;
      go_idle();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         vin = 1'b1;
         rin = 1'b1;
         pin = 8'h30 + 8'(hs);
         #1;
         exp = (c == 3) || (c == 7);
         vectors++;
         if (vo[3] !== exp || ro[3] !== exp || po[3] !== pin) begin
            errors++;
            $display("FAIL delay3 cycle%0d: valid=%b ready=%b payload=%h, want %b %b %h",
                     c, vo[3], ro[3], po[3], exp, exp, pin);
         end
         if (vo[3] && ro[3]) hs++;
      end
   endtask

   task automatic test_backpressure();
      int   hs = 0;
      logic exp_v;
      logic exp_r;
      go_idle();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         vin = (c <= 7);
         rin = (c == 7);
         pin = 8'hA5;
         #1;
         exp_v = (c >= 2) && (c <= 7);
         exp_r = (c == 7);
         vectors++;
         if (vo[2] !== exp_v || ro[2] !== exp_r || (exp_v && po[2] !== 8'hA5)) begin
            errors++;
            $display("FAIL backpressure cycle%0d: valid=%b ready=%b payload=%h, want %b %b a5",
                     c, vo[2], ro[2], po[2], exp_v, exp_r);
         end
         if (vo[2] && rin) hs++;
      end
      vectors++;
      if (hs != 1) begin
         errors++;
         $display("FAIL backpressure_count: handshakes=%0d, want 1", hs);
      end
   endtask

   task automatic test_reset_mid();
      logic exp;
      go_idle();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         vin = 1'b1;
         rin = (c >= 3);
         pin = 8'h44;
         #1;
         if (c == 2) begin
            vectors++;
            if (vo[2] !== 1'b1) begin
               errors++;
               $display("FAIL pre_reset_d2: valid=%b, want 1", vo[2]);
            end
            rst = 1'b1;
            #1;
            vectors++;
            if (vo[4] !== 1'b0 || ro[4] !== 1'b0 || vo[2] !== 1'b0 || ro[2] !== 1'b0) begin
               errors++;
               $display("FAIL async_reset: d4 %b%b d2 %b%b, want 00 00", vo[4], ro[4], vo[2], ro[2]);
            end
            #1;
            rst = 1'b0;
         end else begin
            exp = (c == 6);
            vectors++;
            if (vo[4] !== exp || ro[4] !== exp) begin
               errors++;
               $display("FAIL reset_restart cycle%0d: valid=%b ready=%b, want %b %b",
                        c, vo[4], ro[4], exp, exp);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int   hs = 0;
      logic exp;
      go_idle();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         vin = 1'b1;
         rin = 1'b1;
         pin = 8'h60 + 8'(hs);
         #1;
         exp = (c % 2 == 1);
         vectors++;
         if (vo[1] !== exp || ro[1] !== exp) begin
            errors++;
            $display("FAIL b2b cycle%0d: valid=%b ready=%b, want %b %b", c, vo[1], ro[1], exp, exp);
         end
         if (vo[1] && ro[1]) begin
            vectors++;
            if (po[1] !== 8'h60 + 8'(hs)) begin
               errors++;
               $display("FAIL b2b_payload: got %h, want %h", po[1], 8'h60 + 8'(hs));
            end
            hs++;
         end
      end
      vectors++;
      if (hs != 5) begin
         errors++;
         $display("FAIL b2b_count: handshakes=%0d, want 5", hs);
      end
   endtask

   task automatic test_random();
      logic [15:0] lfsr_m;
      int          sent = 0;
      int          got = 0;
      int          cycles = 0;
      int          age = 0;
      int          exp_d = 0;
      bit          fresh = 1'b1;
      bit          seen = 1'b0;
      logic        dn;
      logic        up;
      @(negedge clk);
      rst = 1'b1;
      vin = 1'b0;
      rin = 1'b0;
      #2;
      rst = 1'b0;
      lfsr_m = 16'hACE1;
      while (got < 1000 && cycles < 40000) begin
         vin = 1'b1;
         pin = sent[7:0];
         rin = 1'($urandom_range(0, 1));
         #1;
         if (fresh) begin
            exp_d = int'(lfsr_m[3:0]);
            age   = 0;
            seen  = 1'b0;
            fresh = 1'b0;
         end
         if (vo[5] && !seen) begin
            seen = 1'b1;
            vectors++;
            if (age != exp_d) begin
               errors++;
               $display("FAIL rnd_delay xfer%0d: delay=%0d, want %0d", sent, age, exp_d);
            end
         end
         vectors++;
         if (ro[5] !== (vo[5] & rin)) begin
            errors++;
            $display("FAIL rnd_ready xfer%0d: ready_o=%b valid_o=%b ready_i=%b", sent, ro[5], vo[5], rin);
         end
         dn = vo[5] & rin;
         up = ro[5];
         if (dn) begin
            vectors++;
            if (po[5] !== got[7:0]) begin
               errors++;
               $display("FAIL rnd_order: got %h, want %h", po[5], got[7:0]);
            end
            got++;
         end
         if (up) begin
            sent++;
            fresh = 1'b1;
         end
         age++;
         cycles++;
         @(posedge clk);
         lfsr_m = lfsr_next(lfsr_m);
         @(negedge clk);
      end
      vectors++;
      if (got != 1000 || sent != got) begin
         errors++;
         $display("FAIL rnd_count: delivered=%0d accepted=%0d, want 1000 1000", got, sent);
      end
   endtask

   initial begin
      rst = 1'b1;
      vin = 1'b0;
      rin = 1'b0;
      pin = 8'h00;
      test_reset();
      test_passthrough();
      test_fixed_delay3();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
